// File: rtl/dm_ext.sv
// dm_ext: byte-addressable 32-bit data memory for the MEM stage.
// It supports word, halfword and byte stores, and sign- or zero-extending
// sub-word loads. Misaligned or reserved accesses are flagged as faults.
// After every reset the array is zeroed by a sweep of one word per cycle.
module dm_ext #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [2:0]            read_mode,
    output logic [31:0]           read_result,
    output logic                  load_fault,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [1:0]            write_mode,
    input  logic [31:0]           write_data,
    output logic                  store_fault,
    output logic                  busy
);

    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int DEPTH  = 2 ** WORD_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t              state_reg, state_next;
    logic [WORD_W-1:0]   ptr_reg, ptr_next;
    logic                busy_reg, busy_next;
    logic                store_fault_reg, store_fault_next;

    // Shared write port into the four byte lanes (used by sweep and stores)
    logic [3:0]          lane_we;
    logic [WORD_W-1:0]   wr_idx;
    logic [31:0]         wr_data;

    // Decoded store request
    logic                store_bad;
    logic [3:0]          store_lanes;
    logic [31:0]         store_data;

    // Word currently addressed by the load port
    logic [31:0]         rd_word;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;

    // State register; the array itself is deliberately left alone by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= CLEAR;
            ptr_reg         <= '0;
            busy_reg        <= 1'b1;
            store_fault_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            busy_reg        <= busy_next;
            store_fault_reg <= store_fault_next;
        end
    end

    // Store decode: lane mask, replicated lane data and alignment check
    always_comb begin
        store_bad   = 1'b0;
        store_lanes = 4'b0000;
        store_data  = write_data;
        case (write_mode)
            2'd0: begin
                store_bad   = |write_addr[1:0];
                store_lanes = 4'b1111;
                store_data  = write_data;
            end
            2'd1: begin
                store_bad   = write_addr[0];
                store_lanes = write_addr[1] ? 4'b1100 : 4'b0011;
                store_data  = {2{write_data[15:0]}};
            end
            2'd2: begin
                store_bad   = 1'b0;
                store_lanes = 4'b0001 << write_addr[1:0];
                store_data  = {4{write_data[7:0]}};
            end
            default: begin
                store_bad   = 1'b1;
                store_lanes = 4'b0000;
            end
        endcase
    end

    // Next-state logic: clear sweep, then store handling in READY
    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        busy_next        = busy_reg;
        store_fault_next = 1'b0;
        lane_we          = 4'b0000;
        wr_idx           = write_addr[ADDR_WIDTH-1:2];
        wr_data          = store_data;
        case (state_reg)
            CLEAR: begin
                lane_we  = 4'b1111;
                wr_idx   = ptr_reg;
                wr_data  = '0;
                ptr_next = ptr_reg + 1'b1;
                if (&ptr_reg) begin
                    state_next = READY;
                    busy_next  = 1'b0;
                end
            end
            READY: begin
                if (write_enable) begin
                    if (store_bad) begin
                        store_fault_next = 1'b1;
                    end else begin
                        lane_we = store_lanes;
                    end
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // One byte-wide array per lane so each lane has an independent write enable
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];

            // Lane write; nothing is written while reset is held
            always_ff @(posedge clk) begin
                if (reset_n && lane_we[gi]) begin
                    mem_lane[wr_idx] <= wr_data[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = mem_lane[read_addr[ADDR_WIDTH-1:2]];
        end
    endgenerate

    assign rd_byte = rd_word[{read_addr[1:0], 3'b000} +: 8];
    assign rd_half = read_addr[1] ? rd_word[31:16] : rd_word[15:0];

    // Load extension and fault detection; outputs forced quiet while busy
    always_comb begin
        read_result = '0;
        load_fault  = 1'b0;
        case (read_mode)
            3'd0: begin
                if (|read_addr[1:0]) load_fault = 1'b1;
                else                 read_result = rd_word;
            end
            3'd1: read_result = {{24{rd_byte[7]}}, rd_byte};
            3'd2: read_result = {24'b0, rd_byte};
            3'd3: begin
                if (read_addr[0]) load_fault = 1'b1;
                else              read_result = {{16{rd_half[15]}}, rd_half};
            end
            3'd4: begin
                if (read_addr[0]) load_fault = 1'b1;
                else              read_result = {16'b0, rd_half};
            end
            default: load_fault = 1'b1;
        endcase
        if (busy_reg) begin
            read_result = '0;
            load_fault  = 1'b0;
        end
    end

    assign busy        = busy_reg;
    assign store_fault = store_fault_reg;

endmodule
